// File: rtl/polar_encoder.sv
// Serial-in/serial-out polar encoder: loads K info bits onto the non-frozen u positions,
// runs one butterfly stage per clock (x = u * F^{(x)n}, no bit reversal), then streams x[0..N-1].
module polar_encoder #(
    parameter int             N           = 8,
    parameter int             LOGN        = 3,
    parameter int             K           = 4,
    parameter logic [N-1:0]   FROZEN_MASK = 8'b0001_0111
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in_valid,
    output logic in_ready,
    input  logic in_bit,
    output logic out_valid,
    input  logic out_ready,
    output logic out_bit,
    output logic out_last,
    output logic busy
);

    generate
        if ($countones(FROZEN_MASK) != N - K) begin : g_mask_chk
            $error("FROZEN_MASK popcount must equal N-K");
        end
    endgenerate

    typedef enum logic [1:0] {S_LOAD, S_ENC, S_SEND} state_t;

    // Smallest non-frozen index strictly above p (p = -1 gives the first one).
    function automatic logic [LOGN-1:0] f_next(input int p);
        logic [LOGN-1:0] r;
        r = '0;
        for (int j = N - 1; j >= 0; j--) begin
            if (j > p && !FROZEN_MASK[j]) r = LOGN'(j);
        end
        return r;
    endfunction

    localparam logic [LOGN-1:0] FIRST_INFO = f_next(-1);

    state_t          r_state, w_nxt;
    logic [N-1:0]    r_u, w_bfly;
    logic [LOGN-1:0] r_ptr;
    logic [LOGN:0]   r_cnt;
    logic [LOGN-1:0] r_stg;
    logic [LOGN-1:0] r_idx;
    logic            w_load_last, w_enc_last;

    assign w_load_last = (r_cnt == (LOGN+1)'(K - 1));
    assign w_enc_last  = (r_stg == LOGN'(LOGN - 1));

    // Butterfly for the current stage only; pairs are (i, i+2^s) with bit s of i clear.
    always_comb begin
        w_bfly = r_u;
        for (int s = 0; s < LOGN; s++) begin
            if (r_stg == LOGN'(s)) begin
                for (int i = 0; i < N; i++) begin
                    if (((i >> s) & 1) == 0) w_bfly[i] = r_u[i] ^ r_u[i + (1 << s)];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_LOAD;
        else        r_state <= w_nxt;
    end

    always_comb begin
        w_nxt     = r_state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_bit   = 1'b0;
        out_last  = 1'b0;
        busy      = 1'b0;
        case (r_state)
            S_LOAD: begin
                in_ready = 1'b1;
                if (in_valid && w_load_last) w_nxt = S_ENC;
            end
            S_ENC: begin
                busy = 1'b1;
                if (w_enc_last) w_nxt = S_SEND;
            end
            S_SEND: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                out_bit   = r_u[r_idx];
                out_last  = (r_idx == LOGN'(N - 1));
                if (out_ready && out_last) w_nxt = S_LOAD;
            end
            default: w_nxt = S_LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_u   <= '0;
            r_ptr <= FIRST_INFO;
            r_cnt <= '0;
            r_stg <= '0;
            r_idx <= '0;
        end else begin
            case (r_state)
                S_LOAD: begin
                    if (in_valid) begin
                        r_u[r_ptr] <= in_bit;
                        r_ptr      <= f_next(int'(r_ptr));
                        r_cnt      <= r_cnt + 1'b1;
                        if (w_load_last) begin
                            r_cnt <= '0;
                            r_stg <= '0;
                            r_ptr <= FIRST_INFO;
                        end
                    end
                end
                S_ENC: begin
                    r_u   <= w_bfly;
                    r_stg <= r_stg + 1'b1;
                    if (w_enc_last) r_idx <= '0;
                end
                S_SEND: begin
                    if (out_ready) begin
                        r_idx <= r_idx + 1'b1;
                        // Clearing u here leaves frozen positions at 0 for the next frame.
                        if (out_last) begin
                            r_u   <= '0;
                            r_ptr <= FIRST_INFO;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_polar_encoder.sv
// Scoreboard bench for polar_encoder (N=8, K=4, info set {3,5,6,7}): directed frames,
// gaps, backpressure and mid-frame reset.
module tb_polar_encoder;
    localparam int N = 8, LOGN = 3, K = 4;

    logic clk = 1'b0, rst_n = 1'b1;
    logic in_valid = 1'b0, in_bit = 1'b0, out_ready = 1'b1;
    logic in_ready, out_valid, out_bit, out_last, busy;

    polar_encoder #(.N(N), .LOGN(LOGN), .K(K), .FROZEN_MASK(8'b0001_0111)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_bit(in_bit),
        .out_valid(out_valid), .out_ready(out_ready), .out_bit(out_bit),
        .out_last(out_last), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_err = 0, cyc = 0, acc_cyc = 0;
    bit lat_armed = 0, bp_en = 0;
    logic [1:0] exp_q[$];   // {last, bit}
    logic prev_stall = 1'b0, prev_bit = 1'b0, prev_last = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d want %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    initial forever begin
        @(posedge clk); #1;
        if (bp_en) out_ready = ~out_ready;
        else       out_ready = 1'b1;
    end

    // Monitor: sampled on the falling edge, transfers happen on the next rising edge.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("ready_valid_excl", {31'd0, in_ready & out_valid}, 0);
            if (prev_stall && out_valid) begin
                chk("stall_bit", {31'd0, out_bit}, {31'd0, prev_bit});
                chk("stall_last", {31'd0, out_last}, {31'd0, prev_last});
            end
            if (out_valid && lat_armed) begin
                chk("latency", cyc - acc_cyc, LOGN);
                lat_armed = 0;
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) chk("unexpected_out", 1, 0);
                else begin
                    logic [1:0] e;
                    e = exp_q.pop_front();
                    chk("out_bit", {31'd0, out_bit}, {31'd0, e[0]});
                    chk("out_last", {31'd0, out_last}, {31'd0, e[1]});
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_bit   = out_bit;
            prev_last  = out_last;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic push_exp(input logic [7:0] x);
        for (int i = 0; i < N; i++) exp_q.push_back({(i == N - 1), x[i]});
    endtask

    // ib[k] is the k-th info bit sent; x[i] is codeword bit i.
    task automatic feed(input logic [3:0] ib, input int maxgap, input bit hold_valid);
        for (int k = 0; k < K; k++) begin
            int gap, t;
            bit ok;
            gap = (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0;
            in_valid = 1'b0;
            repeat (gap) begin @(posedge clk); #1; end
            in_valid = 1'b1;
            in_bit   = ib[k];
            t = 0; ok = 0;
            while (!ok && t < 50) begin
                @(negedge clk); ok = in_ready;
                @(posedge clk); #1; t++;
            end
            if (!ok) chk("accept_timeout", 0, 1);
            in_valid = 1'b0;
            if (k == K - 1) begin acc_cyc = cyc; lat_armed = 1; end
        end
        if (hold_valid) begin
            in_valid = 1'b1; in_bit = 1'b1;
            repeat (LOGN + 4) begin @(posedge clk); #1; end
            in_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((exp_q.size() != 0 || !in_ready) && t < 200) begin @(posedge clk); #1; t++; end
        chk("drain_left", exp_q.size(), 0);
        chk("drain_in_ready", {31'd0, in_ready}, 1);
        chk("drain_busy", {31'd0, busy}, 0);
    endtask

    task automatic frame(input logic [3:0] ib, input logic [7:0] x, input int maxgap, input bit hold);
        push_exp(x);
        feed(ib, maxgap, hold);
        drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #2 rst_n = 1'b0;
        #20;
        chk("rst_out_valid", {31'd0, out_valid}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_in_ready", {31'd0, in_ready}, 1);
        chk("rst_out_bit", {31'd0, out_bit}, 0);
        chk("rst_out_last", {31'd0, out_last}, 0);
        @(negedge clk); #2 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_in_ready", {31'd0, in_ready}, 1);

        frame(4'b0001, 8'b0000_1111, 0, 0);   // 1,0,0,0
        frame(4'b0010, 8'b0011_0011, 0, 0);   // 0,1,0,0
        frame(4'b1000, 8'b1111_1111, 0, 0);   // 0,0,0,1
        frame(4'b1111, 8'b1001_0110, 0, 0);   // 1,1,1,1

        bp_en = 1;
        frame(4'b1111, 8'b1001_0110, 0, 0);
        bp_en = 0;

        frame(4'b0010, 8'b0011_0011, 4, 1);   // gaps + in_valid held during ENC/SEND

        // Reset after three codeword bits have gone out.
        push_exp(8'b0000_1111);
        feed(4'b0001, 0, 0);
        begin
            int t;
            t = 0;
            while (exp_q.size() > 5 && t < 50) begin @(negedge clk); t++; end
            chk("mid_wait_sent3", exp_q.size(), 5);
        end
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", {31'd0, out_valid}, 0);
        chk("mid_rst_busy", {31'd0, busy}, 0);
        chk("mid_rst_in_ready", {31'd0, in_ready}, 1);
        exp_q.delete();
        lat_armed = 0;
        @(negedge clk); #2 rst_n = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        chk("mid_rst_no_output", {31'd0, out_valid}, 0);
        frame(4'b1000, 8'b1111_1111, 0, 0);

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
